// File: rtl/md_issue_ctrl_pkg.sv
// rtl/md_issue_ctrl_pkg.sv - alu_ctrl codes, mult/div FSM states and decode helpers
//
// Shared by md_issue_ctrl and md_sign_fix. The M-extension codes occupy one
// aligned block of eight, so alu_ctrl[2:0] is the op index within the block
// and alu_ctrl[2] separates divide from multiply.
package md_issue_ctrl_pkg;

    localparam int MD_CTRL_W = 5;

    localparam logic [MD_CTRL_W-1:0] ALUCTRL_ADD    = 5'h00;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_SUB    = 5'h01;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_AND    = 5'h02;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_OR     = 5'h03;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_XOR    = 5'h04;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_MUL    = 5'h10;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_MULH   = 5'h11;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_MULHSU = 5'h12;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_MULHU  = 5'h13;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_DIV    = 5'h14;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_DIVU   = 5'h15;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_REM    = 5'h16;
    localparam logic [MD_CTRL_W-1:0] ALUCTRL_REMU   = 5'h17;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_ISSUE,
        MD_WAIT,
        MD_DONE,
        MD_DRAIN
    } md_state_e;

    // Index within the M-extension block (alu_ctrl[2:0]).
    typedef enum logic [2:0] {
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } md_op_e;

    function automatic logic alu_ctrl_is_md(input logic [MD_CTRL_W-1:0] c);
        return (c >= ALUCTRL_MUL) && (c <= ALUCTRL_REMU);
    endfunction

    function automatic logic alu_ctrl_is_div(input logic [MD_CTRL_W-1:0] c);
        return (c >= ALUCTRL_DIV) && (c <= ALUCTRL_REMU);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - operand magnitude conversion and result sign fix-up (combinational)
//
// Ports:
//   op      in   md_op_e   op currently in EX (operand side)
//   rs1/rs2 in   XLEN      raw operands
//   op_q    in   md_op_e   op latched at issue (result side)
//   neg_q   in   1         latched negate flag
//   md_out  in   2*XLEN    raw unit result
//   opnd_a  out  XLEN      unsigned operand A for the unit
//   opnd_b  out  XLEN      unsigned operand B for the unit
//   neg     out  1         negate flag for the op in EX
//   fixed   out  XLEN      selected and sign-corrected result
module md_sign_fix
    import md_issue_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  md_op_e            op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  md_op_e            op_q,
    input  logic              neg_q,
    input  logic [2*XLEN-1:0] md_out,
    output logic [XLEN-1:0]   opnd_a,
    output logic [XLEN-1:0]   opnd_b,
    output logic              neg,
    output logic [XLEN-1:0]   fixed
);

    localparam int W2 = 2 * XLEN;

    logic            s1;
    logic            s2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo_n;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] prod_hi_n;

    always_comb begin
        s1   = rs1[XLEN-1];
        s2   = rs2[XLEN-1];
        // The most negative value maps to itself, which is its correct unsigned magnitude.
        abs1 = s1 ? (~rs1 + XLEN'(1)) : rs1;
        abs2 = s2 ? (~rs2 + XLEN'(1)) : rs2;

        opnd_a = rs1;
        opnd_b = rs2;
        neg    = 1'b0;
        case (op)
            OP_MULH, OP_DIV: begin
                opnd_a = abs1;
                opnd_b = abs2;
                neg    = s1 ^ s2;
            end
            OP_MULHSU: begin
                opnd_a = abs1;
                neg    = s1;
            end
            OP_REM: begin
                opnd_a = abs1;
                opnd_b = abs2;
                neg    = s1;
            end
            default: ;
        endcase

        lo   = md_out[XLEN-1:0];
        hi   = md_out[W2-1:XLEN];
        lo_n = neg_q ? (~lo + XLEN'(1)) : lo;
        hi_n = neg_q ? (~hi + XLEN'(1)) : hi;
        // High half of a 2*XLEN negate: the +1 only carries into the high half
        // when the low half is zero.
        prod_hi_n = neg_q ? (~hi + XLEN'(lo == '0)) : hi;

        case (op_q)
            OP_MUL:                       fixed = lo;
            OP_MULH, OP_MULHSU, OP_MULHU: fixed = prod_hi_n;
            OP_DIV, OP_DIVU:              fixed = lo_n;
            default:                      fixed = hi_n;
        endcase
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - EX-stage mult/div issue controller (initiator side of md_valid/md_ready)
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_valid/ex_flush EX occupancy and squash
//   alu_ctrl          operation code
//   rs1_data/rs2_data operands
//   md_ready/md_out   unit completion pulse and {hi,lo} / {rem,quot} result
//   md_valid          one-cycle issue pulse
//   md_mode           0 multiply, 1 divide
//   md_in_a/md_in_b   unsigned operands to the unit
//   stall             hold PC/IF/ID/EX
//   result            final result, valid with result_valid
//   result_valid      one-cycle completion pulse
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = MD_CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              md_ready,
    input  logic [2*XLEN-1:0] md_out,
    output logic              md_valid,
    output logic              md_mode,
    output logic [XLEN-1:0]   md_in_a,
    output logic [XLEN-1:0]   md_in_b,
    output logic              stall,
    output logic [XLEN-1:0]   result,
    output logic              result_valid
);

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state;
    md_state_e       state_n;
    md_op_e          op_in;
    md_op_e          op_q;
    logic            neg_q;
    logic            neg_in;
    logic            is_md;
    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            is_rem;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] opnd_a;
    logic [XLEN-1:0] opnd_b;
    logic [XLEN-1:0] fixed;

    md_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op     (op_in),
        .rs1    (rs1_data),
        .rs2    (rs2_data),
        .op_q   (op_q),
        .neg_q  (neg_q),
        .md_out (md_out),
        .opnd_a (opnd_a),
        .opnd_b (opnd_b),
        .neg    (neg_in),
        .fixed  (fixed)
    );

    // Decode and the div-by-zero / overflow results, which never reach the unit.
    always_comb begin
        is_md    = alu_ctrl_is_md(alu_ctrl);
        op_in    = md_op_e'(alu_ctrl[2:0]);
        accept   = ex_valid & is_md & ~ex_flush;
        is_rem   = (op_in == OP_REM) || (op_in == OP_REMU);
        div_zero = alu_ctrl_is_div(alu_ctrl) && (rs2_data == '0);
        div_ovf  = is_md && ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (rs1_data == XMIN) && (rs2_data == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = is_rem ? rs1_data : '1;
        end else begin
            special_res = is_rem ? '0 : XMIN;
        end
    end

    always_comb begin
        state_n      = state;
        md_valid     = 1'b0;
        result_valid = 1'b0;
        // Gated by rst_n so every output reads 0 while reset is held.
        stall        = rst_n & ex_valid & is_md & ~ex_flush & (state != MD_DONE);
        case (state)
            MD_IDLE: begin
                if (accept) begin
                    state_n = special ? MD_DONE : MD_ISSUE;
                end
            end
            MD_ISSUE: begin
                // The pulse goes out even when flushed; the unit is then drained.
                md_valid = 1'b1;
                state_n  = ex_flush ? MD_DRAIN : MD_WAIT;
            end
            MD_WAIT: begin
                if (md_ready) begin
                    state_n = ex_flush ? MD_IDLE : MD_DONE;
                end else if (ex_flush) begin
                    state_n = MD_DRAIN;
                end
            end
            MD_DONE: begin
                result_valid = ~ex_flush;
                state_n      = MD_IDLE;
            end
            MD_DRAIN: begin
                if (md_ready) begin
                    state_n = MD_IDLE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MD_IDLE;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            md_mode <= 1'b0;
            md_in_a <= '0;
            md_in_b <= '0;
            result  <= '0;
        end else begin
            state <= state_n;
            case (state)
                MD_IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        md_mode <= alu_ctrl_is_div(alu_ctrl);
                        if (special) begin
                            result <= special_res;
                        end else begin
                            md_in_a <= opnd_a;
                            md_in_b <= opnd_b;
                            neg_q   <= neg_in;
                        end
                    end
                end
                MD_WAIT: begin
                    // md_out is only meaningful in the md_ready cycle.
                    if (md_ready) begin
                        result <= fixed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
